instr_mem_loader: RTL

Parametrised, run-time-loadable instruction memory for the MIPS datapath. The memory array is initialised from an external word stream over a valid/ready load port instead of hard-coded contents. It keeps a per-program entry-point table, so the control unit can start any of NUM_PROGS loaded programs by index. Fetch is a registered, one-cycle-latency read that stalls while a load is in progress.

---
 rtl/mips_mem_pkg.sv | 15 +
 rtl/instr_mem_loader_if.sv | 57 +++++
 rtl/imem_entry_table.sv | 33 +++
 rtl/instr_mem_loader.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the run-time-loadable MIPS instruction memory.
package mips_mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;

  localparam logic [DEF_DATA_W-1:0] NOP = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Load, fetch and entry-point signals of instr_mem_loader.
// INSTR_PARITY_EN adds the parity_err signal.
interface instr_mem_loader_if import mips_mem_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int PROG_W = 2
);

  logic              load_start;
  logic [ADDR_W-1:0] load_base;
  logic [PROG_W-1:0] load_prog;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] instrucao;
  logic              instr_valid;
  logic              busy;
  logic [PROG_W-1:0] prog_sel;
  logic [ADDR_W-1:0] entry_addr;
  logic              addr_err;
`ifdef INSTR_PARITY_EN
  logic              parity_err;

  modport master (
    output load_start, load_base, load_prog, load_valid, load_data, load_last,
           fetch_en, fetch_addr, prog_sel,
    input  load_ready, load_done, instrucao, instr_valid, busy, entry_addr,
           addr_err, parity_err
  );

  modport slave (
    input  load_start, load_base, load_prog, load_valid, load_data, load_last,
           fetch_en, fetch_addr, prog_sel,
    output load_ready, load_done, instrucao, instr_valid, busy, entry_addr,
           addr_err, parity_err
  );
`else
  modport master (
    output load_start, load_base, load_prog, load_valid, load_data, load_last,
           fetch_en, fetch_addr, prog_sel,
    input  load_ready, load_done, instrucao, instr_valid, busy, entry_addr,
           addr_err
  );

  modport slave (
    input  load_start, load_base, load_prog, load_valid, load_data, load_last,
           fetch_en, fetch_addr, prog_sel,
    output load_ready, load_done, instrucao, instr_valid, busy, entry_addr,
           addr_err
  );
`endif

endinterface

// File: rtl/imem_entry_table.sv
// Per-program entry-point register file: one write port, registered read.
module imem_entry_table #(
  parameter int ADDR_W    = 10,
  parameter int NUM_PROGS = 4,
  parameter int PROG_W    = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [PROG_W-1:0] wr_idx,
  input  logic [ADDR_W-1:0] wr_data,
  input  logic [PROG_W-1:0] rd_idx,
  output logic [ADDR_W-1:0] rd_data
);

  logic [ADDR_W-1:0] slots [NUM_PROGS];

  // Slot storage; every slot clears on reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_PROGS; i++) slots[i] <= '0;
    end else if (wr_en) begin
      slots[wr_idx] <= wr_data;
    end
  end

  // Registered read: a write on one edge is visible on rd_data one edge later.
  always_ff @(posedge clock) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= slots[rd_idx];
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Run-time-loadable instruction memory with entry-point table.
// Optional macro INSTR_PARITY_EN: stores an even-parity bit per word and
// reports parity_err on fetch.
module instr_mem_loader import mips_mem_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DEPTH     = 128,
  parameter int NUM_PROGS = 4,
  parameter int PROG_W    = 2
) (
  input logic              clock,
  input logic              reset_n,
  instr_mem_loader_if.slave bus
);

`ifdef INSTR_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [DATA_W-1:0] NOP_W   = DATA_W'(NOP);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_word;
  logic              accept, tbl_we, rd_req;
  logic              wr_in_range, rd_in_range;

  assign wr_in_range = {1'b0, wr_ptr} < DEPTH_L;
  assign rd_in_range = {1'b0, bus.fetch_addr} < DEPTH_L;
  assign rd_word     = mem[bus.fetch_addr[IDX_W-1:0]];

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state, handshake outputs and internal strobes.
  always_comb begin
    state_d        = state_q;
    bus.load_ready = 1'b0;
    bus.load_done  = 1'b0;
    bus.busy       = 1'b0;
    accept         = 1'b0;
    tbl_we         = 1'b0;
    rd_req         = 1'b0;
    case (state_q)
      IDLE: begin
        rd_req = bus.fetch_en;
        if (bus.load_start) begin
          tbl_we  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        bus.busy       = 1'b1;
        bus.load_ready = 1'b1;
        accept         = bus.load_valid;
        if (bus.load_valid && bus.load_last) state_d = DONE;
      end
      DONE: begin
        bus.load_done = 1'b1;
        rd_req        = bus.fetch_en;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write pointer: latched at session start, advances (and wraps) per accepted word.
  always_ff @(posedge clock) begin
    if (!reset_n)    wr_ptr <= '0;
    else if (tbl_we) wr_ptr <= bus.load_base;
    else if (accept) wr_ptr <= wr_ptr + 1'b1;
  end

  // Array write; contents survive reset, out-of-range words are dropped.
  always_ff @(posedge clock) begin
    if (reset_n && accept && wr_in_range) begin
`ifdef INSTR_PARITY_EN
      mem[wr_ptr[IDX_W-1:0]] <= {^bus.load_data, bus.load_data};
`else
      mem[wr_ptr[IDX_W-1:0]] <= bus.load_data;
`endif
    end
  end

  // Registered fetch port and range-error pulse.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      bus.instrucao   <= '0;
      bus.instr_valid <= 1'b0;
      bus.addr_err    <= 1'b0;
`ifdef INSTR_PARITY_EN
      bus.parity_err  <= 1'b0;
`endif
    end else begin
      bus.instr_valid <= rd_req;
      bus.addr_err    <= (accept && !wr_in_range) || (rd_req && !rd_in_range);
`ifdef INSTR_PARITY_EN
      bus.parity_err  <= 1'b0;
`endif
      if (rd_req) begin
        if (!rd_in_range) begin
          bus.instrucao <= NOP_W;
        end else begin
`ifdef INSTR_PARITY_EN
          // Stored word plus parity bit must XOR to zero.
          if (^rd_word) begin
            bus.instrucao  <= NOP_W;
            bus.parity_err <= 1'b1;
          end else begin
            bus.instrucao  <= rd_word[DATA_W-1:0];
          end
`else
          bus.instrucao <= rd_word;
`endif
        end
      end
    end
  end

  imem_entry_table #(
    .ADDR_W    (ADDR_W),
    .NUM_PROGS (NUM_PROGS),
    .PROG_W    (PROG_W)
  ) u_entry_table (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_en   (tbl_we),
    .wr_idx  (bus.load_prog),
    .wr_data (bus.load_base),
    .rd_idx  (bus.prog_sel),
    .rd_data (bus.entry_addr)
  );

endmodule
